red_pitaya_pfd_sched: RTL and testbench

Time-multiplexes one shared CORDIC phase pipeline between NCH I/Q requesters, so several phase-frequency detectors can share one phase datapath.
- Arbitrates requests round-robin and issues one sample per cycle to the pipeline.
- Tags each in-flight sample with its channel.
- Routes each returned phase to its channel and unwraps it with a per-channel turn counter.
- Produces a SIGNALBITS-wide integral per channel. Sits between the IQ demodulator low-pass outputs and the PID inputs.

---
 rtl/red_pitaya_pfd_sched.sv | 131 +++++++++++++
 tb/tb_red_pitaya_pfd_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pfd_sched.sv
// red_pitaya_pfd_sched: shares one CORDIC phase pipeline among NCH I/Q channels, unwraps each returned phase per channel.
// Define PFD_SCHED_PRIORITY_EN to give channel 0 strict priority ahead of the round-robin.
module red_pitaya_pfd_sched #(
   parameter int NCH        = 4,
   parameter int CHW        = 2,
   parameter int LPFBITS    = 24,
   parameter int PHASEWIDTH = 15,
   parameter int TURNWIDTH  = 4,
   parameter int SIGNALBITS = 14,
   parameter int LATENCY    = 13
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic [NCH-1:0]             enable_i,
   input  logic [NCH-1:0]             clear_i,
   input  logic [NCH-1:0]             req_valid_i,
   output logic [NCH-1:0]             req_ready_o,
   input  logic [NCH*LPFBITS-1:0]     req_i_i,
   input  logic [NCH*LPFBITS-1:0]     req_q_i,
   output logic [LPFBITS-1:0]         cordic_i_o,
   output logic [LPFBITS-1:0]         cordic_q_o,
   output logic                       cordic_valid_o,
   input  logic [PHASEWIDTH-1:0]      cordic_ph_i,
   output logic [NCH*SIGNALBITS-1:0]  integral_o,
   output logic [NCH-1:0]             out_valid_o,
   output logic [NCH-1:0]             sat_o
);
   localparam int FW = SIGNALBITS - TURNWIDTH;
   logic [NCH-1:0] elig, gnt;
   logic [CHW-1:0] ptr, ptr_nx, gnt_ch, idx, issue_ch, rc;
   logic [CHW:0] sum;
   logic any, ptr_en, rv, unused_ph;
   logic [LATENCY-1:0] tv;
   logic [CHW-1:0] tc [LATENCY];
   assign elig = req_valid_i & enable_i;
   assign any = |elig;
   assign gnt = NCH'(1) << gnt_ch;
   assign req_ready_o = (any && rstn_i) ? gnt : '0;
   assign ptr_nx = (gnt_ch == CHW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
   assign unused_ph = ^cordic_ph_i[PHASEWIDTH-FW-1:0];
   // Scan downward from pointer+NCH-1 so the channel nearest the pointer wins last.
   always_comb begin
      gnt_ch = '0;
      sum = '0;
      idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + (CHW+1)'(i);
         idx = (sum >= (CHW+1)'(NCH)) ? CHW'(sum - (CHW+1)'(NCH)) : CHW'(sum);
`ifdef PFD_SCHED_PRIORITY_EN
         if (elig[idx] && idx != '0) gnt_ch = idx;
`else
         if (elig[idx]) gnt_ch = idx;
`endif
      end
`ifdef PFD_SCHED_PRIORITY_EN
      if (elig[0]) gnt_ch = '0;
`endif
   end
`ifdef PFD_SCHED_PRIORITY_EN
   assign ptr_en = any && gnt_ch != '0;
`else
   assign ptr_en = any;
`endif
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         ptr <= '0;
         cordic_valid_o <= 1'b0;
         cordic_i_o <= '0;
         cordic_q_o <= '0;
         issue_ch <= '0;
         tv <= '0;
         for (int k = 0; k < LATENCY; k++) tc[k] <= '0;
      end else begin
         cordic_valid_o <= any;
         tv <= {tv[LATENCY-2:0], cordic_valid_o};
         tc[0] <= issue_ch;
         for (int k = 1; k < LATENCY; k++) tc[k] <= tc[k-1];
         if (any) begin
            cordic_i_o <= req_i_i[gnt_ch*LPFBITS +: LPFBITS];
            cordic_q_o <= req_q_i[gnt_ch*LPFBITS +: LPFBITS];
            issue_ch <= gnt_ch;
         end
         if (ptr_en) ptr <= ptr_nx;
      end
   assign rv = tv[LATENCY-1];
   assign rc = tc[LATENCY-1];
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic signed [TURNWIDTH-1:0] turns, turns_nx;
      logic [1:0] quad, nquad;
      logic first, sat, ov, hit, up, dn, at_max, at_min;
      logic [SIGNALBITS-1:0] integ;
      assign nquad = cordic_ph_i[PHASEWIDTH-1 -: 2];
      assign hit = rv && rc == CHW'(g) && enable_i[g];
      assign up = !first && quad == 2'b11 && nquad == 2'b00;
      assign dn = !first && quad == 2'b00 && nquad == 2'b11;
      assign at_max = turns == {1'b0, {(TURNWIDTH-1){1'b1}}};
      assign at_min = turns == {1'b1, {(TURNWIDTH-1){1'b0}}};
      assign turns_nx = clear_i[g] ? '0 :
                        (up && !at_max) ? turns + TURNWIDTH'(1) :
                        (dn && !at_min) ? turns - TURNWIDTH'(1) : turns;
      // A result coincident with clear becomes the new reference phase.
      always_ff @(posedge clk_i or negedge rstn_i)
         if (!rstn_i) begin
            turns <= '0;
            quad <= '0;
            first <= 1'b1;
            sat <= 1'b0;
            ov <= 1'b0;
            integ <= '0;
         end else begin
            ov <= hit;
            if (clear_i[g]) begin
               turns <= '0;
               sat <= 1'b0;
               first <= !hit;
            end else if (!enable_i[g]) first <= 1'b1;
            else if (hit) begin
               turns <= turns_nx;
               sat <= sat | (up && at_max) | (dn && at_min);
               first <= 1'b0;
            end
            if (hit) begin
               quad <= nquad;
               integ <= {turns_nx, cordic_ph_i[PHASEWIDTH-1 -: FW]};
            end
         end
      assign out_valid_o[g] = ov;
      assign sat_o[g] = sat;
      assign integral_o[g*SIGNALBITS +: SIGNALBITS] = integ;
   end
endmodule

// File: tb/tb_red_pitaya_pfd_sched.sv
// tb_red_pitaya_pfd_sched: randomized stimulus checked against a behavioural scheduler/unwrap model.
module tb_red_pitaya_pfd_sched;
   localparam int NCH = 4, CHW = 2, LPFBITS = 24, PW = 15, TW = 4, SB = 14, LAT = 13;
   logic clk = 1'b0;
   logic rstn_i = 1'b0;
   logic [NCH-1:0] enable_i = '0, clear_i = '0, req_valid_i = '0;
   logic [NCH-1:0] req_ready_o, out_valid_o, sat_o;
   logic [NCH*LPFBITS-1:0] req_i_i = '0, req_q_i = '0;
   logic [LPFBITS-1:0] cordic_i_o, cordic_q_o;
   logic cordic_valid_o;
   logic [PW-1:0] cordic_ph_i = '0;
   logic [NCH*SB-1:0] integral_o;

   red_pitaya_pfd_sched #(.NCH(NCH), .CHW(CHW), .LPFBITS(LPFBITS), .PHASEWIDTH(PW),
                          .TURNWIDTH(TW), .SIGNALBITS(SB), .LATENCY(LAT)) dut (
      .clk_i(clk), .rstn_i(rstn_i), .enable_i(enable_i), .clear_i(clear_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i_i(req_i_i), .req_q_i(req_q_i),
      .cordic_i_o(cordic_i_o), .cordic_q_o(cordic_q_o), .cordic_valid_o(cordic_valid_o),
      .cordic_ph_i(cordic_ph_i), .integral_o(integral_o), .out_valid_o(out_valid_o), .sat_o(sat_o));

   always #5 clk = ~clk;

   typedef struct {int due; int ch;} tag_t;
   tag_t inflight[$];
   int n_cmp = 0, n_err = 0, cyc = 0, m_ptr = 0;
   int m_turns[NCH];
   int m_phase[NCH];
   bit m_first[NCH];
   logic [NCH-1:0] m_sat, m_ov;
   logic [NCH*SB-1:0] m_int;
   logic [LPFBITS-1:0] m_ci, m_cq;
   logic m_cv;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [NCH-1:0] elig);
`ifdef PFD_SCHED_PRIORITY_EN
      if (elig[0]) return 0;
`endif
      for (int i = 0; i < NCH; i++) begin
         int c = (m_ptr + i) % NCH;
`ifdef PFD_SCHED_PRIORITY_EN
         if (c != 0 && elig[c]) return c;
`else
         if (elig[c]) return c;
`endif
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      for (int c = 0; c < NCH; c++) begin
         m_turns[c] = 0;
         m_phase[c] = 0;
         m_first[c] = 1'b1;
      end
      m_sat = '0; m_ov = '0; m_int = '0; m_ci = '0; m_cq = '0; m_cv = 1'b0;
      inflight.delete();
   endtask

   task automatic check_outputs();
      check("cordic_valid", cordic_valid_o, m_cv);
      check("cordic_i", cordic_i_o, m_ci);
      check("cordic_q", cordic_q_o, m_cq);
      check("out_valid", out_valid_o, m_ov);
      check("integral", integral_o, m_int);
      check("sat", sat_o, m_sat);
   endtask

   task automatic step(input logic [NCH-1:0] v, en, clr, input logic [PW-1:0] ph);
      int g, rch, q_old, q_new, t;
      logic [LPFBITS-1:0] di[NCH];
      logic [LPFBITS-1:0] dq[NCH];
      tag_t tg;
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         di[c] = LPFBITS'($urandom);
         dq[c] = LPFBITS'($urandom);
         req_i_i[c*LPFBITS +: LPFBITS] = di[c];
         req_q_i[c*LPFBITS +: LPFBITS] = dq[c];
      end
      req_valid_i = v; enable_i = en; clear_i = clr; cordic_ph_i = ph;
      #1;
      g = pick(v & en);
      check("ready", req_ready_o, (g < 0) ? 64'd0 : (64'd1 << g));
      m_cv = (g >= 0);
      if (g >= 0) begin
         m_ci = di[g];
         m_cq = dq[g];
         tg.due = cyc + 1 + LAT;
         tg.ch = g;
         inflight.push_back(tg);
`ifdef PFD_SCHED_PRIORITY_EN
         if (g != 0) m_ptr = (g + 1) % NCH;
`else
         m_ptr = (g + 1) % NCH;
`endif
      end
      rch = -1;
      if (inflight.size() > 0 && inflight[0].due == cyc) begin
         tg = inflight.pop_front();
         rch = tg.ch;
      end
      for (int c = 0; c < NCH; c++) begin
         m_ov[c] = (rch == c) && en[c];
         if (m_ov[c]) begin
            if (clr[c]) begin
               m_turns[c] = 0;
               m_sat[c] = 1'b0;
            end else if (!m_first[c]) begin
               q_old = m_phase[c] >> (PW - 2);
               q_new = int'(ph) >> (PW - 2);
               t = m_turns[c] + ((q_old == 3 && q_new == 0) ? 1 : (q_old == 0 && q_new == 3) ? -1 : 0);
               if (t > 2**(TW-1) - 1) begin t = 2**(TW-1) - 1; m_sat[c] = 1'b1; end
               if (t < -(2**(TW-1))) begin t = -(2**(TW-1)); m_sat[c] = 1'b1; end
               m_turns[c] = t;
            end
            m_first[c] = 1'b0;
            m_phase[c] = int'(ph);
            m_int[c*SB +: SB] = SB'(((m_turns[c] & (2**TW - 1)) << (SB - TW)) | (m_phase[c] >> (PW - SB + TW)));
         end else if (clr[c]) begin
            m_turns[c] = 0;
            m_sat[c] = 1'b0;
            m_first[c] = 1'b1;
         end else if (!en[c]) m_first[c] = 1'b1;
      end
      cyc++;
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic drain(input logic [PW-1:0] ph);
      repeat (LAT + 3) step('0, '1, '0, ph);
   endtask

   task automatic pair_returns(input int ch, input logic [PW-1:0] a, b, input int exp_turns);
      logic [NCH-1:0] m;
      logic [SB-1:0] exp_int;
      m = NCH'(1) << ch;
      step(m, '1, '0, '0);
      step(m, '1, '0, '0);
      repeat (LAT - 1) step('0, '1, '0, '0);
      step('0, '1, '0, a);
      step('0, '1, '0, b);
      exp_int = SB'(((exp_turns & (2**TW - 1)) << (SB - TW)) | (int'(b) >> (PW - SB + TW)));
      check("pair_integral", integral_o[ch*SB +: SB], exp_int);
   endtask

   initial begin
      logic [NCH-1:0] en, clr;
      logic [PW-1:0] ph;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      check("ready_reset", req_ready_o, 0);
      @(negedge clk);
      rstn_i = 1'b1;
      repeat (200) step('1, '1, '0, PW'($urandom));
      en = '1;
      repeat (2000) begin
         if ($urandom_range(19) == 0) en[$urandom_range(NCH-1)] ^= 1'b1;
         clr = '0;
         for (int c = 0; c < NCH; c++) if ($urandom_range(31) == 0) clr[c] = 1'b1;
         step(NCH'($urandom), en, clr, PW'($urandom));
      end
      drain('0);
      step('0, '1, 4'b0010, '0);
      pair_returns(1, 15'h7000, 15'h0800, 1);
      pair_returns(1, 15'h0800, 15'h7800, 0);
      step('0, '1, 4'b0100, '0);
      ph = '0;
      repeat (100) begin
         step(4'b0100, '1, '0, ph);
         ph = ph + PW'(16'h1000);
      end
      check("sat2_after_wraps", sat_o[2], 1);
      step('0, '1, 4'b0100, '0);
      check("sat2_cleared", sat_o[2], 0);
      drain('0);
      check("turns2_cleared", integral_o[2*SB + SB - TW +: TW], 0);
      step(4'b0001, '1, '0, '0);
      repeat (LAT) step('0, '1, '0, '0);
      ph = 15'h0400;
      step('0, '1, 4'b0001, ph);
      check("clr_hit_strobe0", out_valid_o[0], 1);
      check("clr_hit_int0", integral_o[SB-1:0], SB'(ph >> (PW - SB + TW)));
      repeat (30) step(NCH'($urandom), '1, '0, PW'($urandom));
      @(negedge clk);
      rstn_i = 1'b0;
      req_valid_i = '0; enable_i = '0; clear_i = '0;
      #1;
      model_reset();
      check_outputs();
      repeat (2) @(negedge clk);
      rstn_i = 1'b1;
      repeat (300) step(NCH'($urandom), '1, '0, PW'($urandom));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
